// File: rtl/rv32_bus_arbiter_pkg.sv
// Shared definitions for the rv32 bus arbiter: FSM state encoding,
// bus field widths and a small saturating-counter helper.
package rv32_bus_arbiter_pkg;

  // Byte-lane write mask width of the external bus.
  localparam int RV32_BUS_MASK_W = 4;

  // Width of the fetch starvation counter; it holds STARVE_LIMIT up to 15.
  localparam int RV32_BUS_CNT_W = 4;

  // Arbiter ownership state. In IDLE the arbiter picks a winner in the
  // same cycle. In a BUSY state the named port owns the bus until it completes.
  typedef enum logic [1:0] {
    IDLE,
    BUSY_INSTR,
    BUSY_DATA
  } rv32_bus_arb_state_t;

  // Increment that saturates at the given limit.
  function automatic logic [RV32_BUS_CNT_W-1:0] sat_inc(
    input logic [RV32_BUS_CNT_W-1:0] value,
    input logic [RV32_BUS_CNT_W-1:0] limit
  );
    if (value >= limit) begin
      return limit;
    end
    return value + 1'b1;
  endfunction

endpackage

// File: rtl/rv32_bus_arbiter.sv
// Two-port bus arbiter for the rv32 core. Fetch and load/store traffic
// share one external memory/peripheral bus. The data side normally wins.
// A starvation counter forces a fetch grant after STARVE_LIMIT consecutive
// data grants that were made while a fetch was waiting. A grant is held
// until the bus reports completion, either ready or ready together with fault.
module rv32_bus_arbiter
  import rv32_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       reset,

  input  logic                       instr_read_in,
  input  logic [31:0]                instr_address_in,
  output logic [31:0]                instr_read_value_out,
  output logic                       instr_ready_out,
  output logic                       instr_fault_out,

  input  logic                       data_read_in,
  input  logic [RV32_BUS_MASK_W-1:0] data_write_mask_in,
  input  logic [31:0]                data_address_in,
  input  logic [31:0]                data_write_value_in,
  output logic [31:0]                data_read_value_out,
  output logic                       data_ready_out,
  output logic                       data_fault_out,

  output logic [31:0]                bus_address_out,
  output logic                       bus_read_out,
  output logic [RV32_BUS_MASK_W-1:0] bus_write_mask_out,
  output logic [31:0]                bus_write_value_out,
  input  logic [31:0]                bus_read_value_in,
  input  logic                       bus_ready_in,
  input  logic                       bus_fault_in
);

  localparam logic [RV32_BUS_CNT_W-1:0] LIMIT = RV32_BUS_CNT_W'(STARVE_LIMIT);

  rv32_bus_arb_state_t       state;
  rv32_bus_arb_state_t       state_next;
  logic [RV32_BUS_CNT_W-1:0] starve_cnt;
  logic [RV32_BUS_CNT_W-1:0] starve_cnt_next;

  logic instr_req;
  logic data_req;
  logic starved;
  logic grant_instr;
  logic grant_data;
  logic sel_instr;
  logic sel_data;

  // A store is any nonzero byte mask. A load is the read strobe.
  assign instr_req = instr_read_in;
  assign data_req  = data_read_in | (|data_write_mask_in);

  // Pick a winner in IDLE and work out which port currently owns the bus payload.
  always_comb begin
    starved     = (starve_cnt == LIMIT) && instr_req;
    grant_instr = 1'b0;
    grant_data  = 1'b0;
    if (state == IDLE) begin
      if (starved) begin
        grant_instr = 1'b1;
      end else if (data_req) begin
        grant_data = 1'b1;
      end else if (instr_req) begin
        grant_instr = 1'b1;
      end
    end
    sel_instr = grant_instr || (state == BUSY_INSTR);
    sel_data  = grant_data  || (state == BUSY_DATA);
  end

  // Ownership transitions and starvation accounting at the start of each grant.
  always_comb begin
    state_next      = state;
    starve_cnt_next = starve_cnt;
    case (state)
      IDLE: begin
        if (grant_instr) begin
          starve_cnt_next = '0;
          if (!bus_ready_in) begin
            state_next = BUSY_INSTR;
          end
        end else if (grant_data) begin
          if (instr_req) begin
            starve_cnt_next = sat_inc(starve_cnt, LIMIT);
          end else begin
            starve_cnt_next = '0;
          end
          if (!bus_ready_in) begin
            state_next = BUSY_DATA;
          end
        end
      end
      BUSY_INSTR, BUSY_DATA: begin
        if (bus_ready_in) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and starvation counter registers. Reset also drops any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_cnt_next;
    end
  end

  // Drive the owner's payload onto the bus and send the completion back to the owner only.
  always_comb begin
    instr_read_value_out = bus_read_value_in;
    data_read_value_out  = bus_read_value_in;
    bus_address_out      = '0;
    bus_read_out         = 1'b0;
    bus_write_mask_out   = '0;
    bus_write_value_out  = '0;
    instr_ready_out      = 1'b0;
    instr_fault_out      = 1'b0;
    data_ready_out       = 1'b0;
    data_fault_out       = 1'b0;

    if (sel_instr) begin
      bus_address_out = instr_address_in;
      bus_read_out    = 1'b1;
      instr_ready_out = bus_ready_in;
      instr_fault_out = bus_ready_in & bus_fault_in;
    end else if (sel_data) begin
      bus_address_out     = data_address_in;
      bus_read_out        = data_read_in;
      bus_write_mask_out  = data_write_mask_in;
      bus_write_value_out = data_write_value_in;
      data_ready_out      = bus_ready_in;
      data_fault_out      = bus_ready_in & bus_fault_in;
    end

    if (reset) begin
      bus_read_out       = 1'b0;
      bus_write_mask_out = '0;
      instr_ready_out    = 1'b0;
      instr_fault_out    = 1'b0;
      data_ready_out     = 1'b0;
      data_fault_out     = 1'b0;
    end
  end

  // A port that owns the bus must keep requesting until it sees its ready.
  instr_hold_a : assert property (@(posedge clk) disable iff (reset)
    (state == BUSY_INSTR) |-> instr_req)
    else $error("rv32_bus_arbiter: fetch request withdrawn while it owns the bus");

  data_hold_a : assert property (@(posedge clk) disable iff (reset)
    (state == BUSY_DATA) |-> data_req)
    else $error("rv32_bus_arbiter: data request withdrawn while it owns the bus");

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Directed bench for rv32_bus_arbiter. A table of per-cycle vectors covers
// single fetch, contention, starvation, a faulting store and the busy lock.
// Hand-written sequences cover reset behaviour.
module tb_rv32_bus_arbiter;
  import rv32_bus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_read_in;
  logic [31:0] instr_address_in;
  logic [31:0] instr_read_value_out;
  logic        instr_ready_out;
  logic        instr_fault_out;
  logic        data_read_in;
  logic [3:0]  data_write_mask_in;
  logic [31:0] data_address_in;
  logic [31:0] data_write_value_in;
  logic [31:0] data_read_value_out;
  logic        data_ready_out;
  logic        data_fault_out;
  logic [31:0] bus_address_out;
  logic        bus_read_out;
  logic [3:0]  bus_write_mask_out;
  logic [31:0] bus_write_value_out;
  logic [31:0] bus_read_value_in;
  logic        bus_ready_in;
  logic        bus_fault_in;

  int checks = 0;
  int errors = 0;

  rv32_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk                  (clk),
    .reset                (reset),
    .instr_read_in        (instr_read_in),
    .instr_address_in     (instr_address_in),
    .instr_read_value_out (instr_read_value_out),
    .instr_ready_out      (instr_ready_out),
    .instr_fault_out      (instr_fault_out),
    .data_read_in         (data_read_in),
    .data_write_mask_in   (data_write_mask_in),
    .data_address_in      (data_address_in),
    .data_write_value_in  (data_write_value_in),
    .data_read_value_out  (data_read_value_out),
    .data_ready_out       (data_ready_out),
    .data_fault_out       (data_fault_out),
    .bus_address_out      (bus_address_out),
    .bus_read_out         (bus_read_out),
    .bus_write_mask_out   (bus_write_mask_out),
    .bus_write_value_out  (bus_write_value_out),
    .bus_read_value_in    (bus_read_value_in),
    .bus_ready_in         (bus_ready_in),
    .bus_fault_in         (bus_fault_in)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic [3:0]  dm;
    logic [31:0] da;
    logic [31:0] dv;
    logic [31:0] brv;
    logic        brdy;
    logic        bflt;
    logic [31:0] e_addr;
    logic        e_read;
    logic [3:0]  e_mask;
    logic [31:0] e_val;
    logic        e_irdy;
    logic        e_iflt;
    logic        e_drdy;
    logic        e_dflt;
    logic [3:0]  e_cnt;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  // Drive one cycle's worth of requester and bus inputs.
  task automatic applyStimulus(input vec_t v);
    instr_read_in       = v.ir;
    instr_address_in    = v.ia;
    data_read_in        = v.dr;
    data_write_mask_in  = v.dm;
    data_address_in     = v.da;
    data_write_value_in = v.dv;
    bus_read_value_in   = v.brv;
    bus_ready_in        = v.brdy;
    bus_fault_in        = v.bflt;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at time %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    checkOutput({p, ".bus_addr"},   bus_address_out, v.e_addr);
    checkOutput({p, ".bus_read"},   32'(bus_read_out), 32'(v.e_read));
    checkOutput({p, ".bus_mask"},   32'(bus_write_mask_out), 32'(v.e_mask));
    checkOutput({p, ".bus_value"},  bus_write_value_out, v.e_val);
    checkOutput({p, ".i_ready"},    32'(instr_ready_out), 32'(v.e_irdy));
    checkOutput({p, ".i_fault"},    32'(instr_fault_out), 32'(v.e_iflt));
    checkOutput({p, ".d_ready"},    32'(data_ready_out), 32'(v.e_drdy));
    checkOutput({p, ".d_fault"},    32'(data_fault_out), 32'(v.e_dflt));
    checkOutput({p, ".i_rvalue"},   instr_read_value_out, v.brv);
    checkOutput({p, ".d_rvalue"},   data_read_value_out, v.brv);
    checkOutput({p, ".starve_cnt"}, 32'(dut.starve_cnt), 32'(v.e_cnt));
  endtask

  task automatic idleInputs();
    vec_t z;
    z = '{1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0,
          32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    applyStimulus(z);
  endtask

  initial begin
    vec_t v;

    // Single fetch with two wait states.
    vecs[0]  = '{1'b1, 32'h100, 1'b0, 4'h0, 32'h0,    32'h0, 32'h0,        1'b0, 1'b0, 32'h100,  1'b1, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[1]  = '{1'b1, 32'h100, 1'b0, 4'h0, 32'h0,    32'h0, 32'h0,        1'b0, 1'b0, 32'h100,  1'b1, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[2]  = '{1'b1, 32'h100, 1'b0, 4'h0, 32'h0,    32'h0, 32'h13,       1'b1, 1'b0, 32'h100,  1'b1, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    // Idle bus, then a stray ready plus fault with no owner.
    vecs[3]  = '{1'b0, 32'h0,   1'b0, 4'h0, 32'h0,    32'h0, 32'h0,        1'b0, 1'b0, 32'h0,    1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[4]  = '{1'b0, 32'h0,   1'b0, 4'h0, 32'h0,    32'h0, 32'h0,        1'b1, 1'b1, 32'h0,    1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    // Contention: data first, then fetch.
    vecs[5]  = '{1'b1, 32'h100, 1'b1, 4'h0, 32'h2000, 32'h0, 32'hAAAA0000, 1'b1, 1'b0, 32'h2000, 1'b1, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[6]  = '{1'b1, 32'h100, 1'b0, 4'h0, 32'h0,    32'h0, 32'h000000BB, 1'b1, 1'b0, 32'h100,  1'b1, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1};
    // Starvation: four data grants, a forced fetch, then data again.
    vecs[7]  = '{1'b1, 32'h100, 1'b1, 4'h0, 32'h2000, 32'h0, 32'h0,        1'b1, 1'b0, 32'h2000, 1'b1, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[8]  = '{1'b1, 32'h100, 1'b1, 4'h0, 32'h2000, 32'h0, 32'h0,        1'b1, 1'b0, 32'h2000, 1'b1, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
    vecs[9]  = '{1'b1, 32'h100, 1'b1, 4'h0, 32'h2000, 32'h0, 32'h0,        1'b1, 1'b0, 32'h2000, 1'b1, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2};
    vecs[10] = '{1'b1, 32'h100, 1'b1, 4'h0, 32'h2000, 32'h0, 32'h0,        1'b1, 1'b0, 32'h2000, 1'b1, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3};
    vecs[11] = '{1'b1, 32'h100, 1'b1, 4'h0, 32'h2000, 32'h0, 32'h0,        1'b1, 1'b0, 32'h100,  1'b1, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4};
    vecs[12] = '{1'b1, 32'h100, 1'b1, 4'h0, 32'h2000, 32'h0, 32'h0,        1'b1, 1'b0, 32'h2000, 1'b1, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[13] = '{1'b1, 32'h100, 1'b0, 4'h0, 32'h0,    32'h0, 32'h0,        1'b1, 1'b0, 32'h100,  1'b1, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1};
    // Store with three wait states. A fault without ready is ignored. Final cycle faults.
    vecs[14] = '{1'b0, 32'h0, 1'b0, 4'h3, 32'h3000, 32'hDEADBEEF, 32'h0,   1'b0, 1'b0, 32'h3000, 1'b0, 4'h3, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[15] = '{1'b0, 32'h0, 1'b0, 4'h3, 32'h3000, 32'hDEADBEEF, 32'h0,   1'b0, 1'b1, 32'h3000, 1'b0, 4'h3, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[16] = '{1'b0, 32'h0, 1'b0, 4'h3, 32'h3000, 32'hDEADBEEF, 32'h0,   1'b0, 1'b0, 32'h3000, 1'b0, 4'h3, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[17] = '{1'b0, 32'h0, 1'b0, 4'h3, 32'h3000, 32'hDEADBEEF, 32'h0,   1'b1, 1'b1, 32'h3000, 1'b0, 4'h3, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0};
    // Lock: fetch owns the bus while data arrives. The fetch faults. Data follows.
    vecs[18] = '{1'b1, 32'h104, 1'b0, 4'h0, 32'h0,    32'h0,        32'h0,  1'b0, 1'b0, 32'h104,  1'b1, 4'h0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[19] = '{1'b1, 32'h104, 1'b1, 4'h0, 32'h2004, 32'h12345678, 32'h0,  1'b0, 1'b0, 32'h104,  1'b1, 4'h0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[20] = '{1'b1, 32'h104, 1'b1, 4'h0, 32'h2004, 32'h12345678, 32'h55, 1'b1, 1'b1, 32'h104,  1'b1, 4'h0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[21] = '{1'b0, 32'h0,   1'b1, 4'h0, 32'h2004, 32'h12345678, 32'h66, 1'b1, 1'b0, 32'h2004, 1'b1, 4'h0, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[22] = '{1'b0, 32'h0,   1'b0, 4'h0, 32'h0,    32'h0,        32'h0,  1'b0, 1'b0, 32'h0,    1'b0, 4'h0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 4'd0};

    // Reset with active requests and a bus completion: every strobe is held low.
    reset = 1'b1;
    idleInputs();
    instr_read_in      = 1'b1;
    instr_address_in   = 32'h100;
    data_read_in       = 1'b1;
    data_write_mask_in = 4'hF;
    bus_ready_in       = 1'b1;
    bus_fault_in       = 1'b1;
    @(negedge clk);
    checkOutput("rst.i_ready",  32'(instr_ready_out), 32'h0);
    checkOutput("rst.d_ready",  32'(data_ready_out), 32'h0);
    checkOutput("rst.i_fault",  32'(instr_fault_out), 32'h0);
    checkOutput("rst.d_fault",  32'(data_fault_out), 32'h0);
    checkOutput("rst.bus_read", 32'(bus_read_out), 32'h0);
    checkOutput("rst.bus_mask", 32'(bus_write_mask_out), 32'h0);
    @(posedge clk);
    #1;
    idleInputs();
    @(negedge clk);
    checkOutput("rst.state", 32'(dut.state), 32'(IDLE));
    checkOutput("rst.cnt",   32'(dut.starve_cnt), 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven cycles.
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkVector(i, vecs[i]);
      @(posedge clk);
      #1;
    end

    // Reset in the second cycle of a load that started while a fetch was waiting.
    v = vecs[22];
    v.ir = 1'b1; v.ia = 32'h108; v.dr = 1'b1; v.da = 32'h2008;
    applyStimulus(v);
    @(negedge clk);
    checkOutput("rmid.c1_addr",  bus_address_out, 32'h2008);
    checkOutput("rmid.c1_ready", 32'(data_ready_out), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rmid.busy",     32'(dut.state), 32'(BUSY_DATA));
    checkOutput("rmid.cnt1",     32'(dut.starve_cnt), 32'h1);
    reset = 1'b1;
    bus_ready_in = 1'b1;
    bus_read_value_in = 32'hCAFE0001;
    @(negedge clk);
    checkOutput("rmid.d_ready",  32'(data_ready_out), 32'h0);
    checkOutput("rmid.i_ready",  32'(instr_ready_out), 32'h0);
    checkOutput("rmid.bus_read", 32'(bus_read_out), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idleInputs();
    @(negedge clk);
    checkOutput("rmid.state",    32'(dut.state), 32'(IDLE));
    checkOutput("rmid.cnt",      32'(dut.starve_cnt), 32'h0);
    checkOutput("rmid.idle_bus", 32'(bus_read_out), 32'h0);
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
